mul_seq_ctrl: RTL

- Sequenced add-shift multiplier controller: one adder of width 2*WIDTH plus shift registers, iterated one partial product per clock.
- Replaces the fully unrolled adder chain where area matters.
- Valid/ready handshake on input and output so it can sit between pipeline stages or a bus-side request queue.
- Produces an unsigned product of two WIDTH-bit operands.

---
 rtl/mul_seq_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential add-shift unsigned multiplier.
// One partial product is accumulated per clock through a single 2*WIDTH-bit adder.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a = multiplicand, b = multiplier)
//   out_valid/out_ready result handshake (r = a*b, 2*WIDTH bits)
//   busy                high while an operation is running or waiting to be taken
module mul_seq_ctrl #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          EARLY_EXIT = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   r,
   output logic                 busy
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [PW-1:0]   r_q, r_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic            accept;
   logic            handshake;
   logic            last_iter;
   logic [PW-1:0]   acc_sum;
   logic [WIDTH-1:0] mplier_shr;

   assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mplier_shr = mplier_q >> 1;
   // Early exit: no set bits remain after this iteration, so further adds contribute nothing.
   assign last_iter  = (cnt_q == CntLast) || (EARLY_EXIT && (mplier_shr == '0));
   assign accept     = in_valid && in_ready;
   assign handshake  = out_valid && out_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept)    state_d = StRun;
         StRun:   if (last_iter) state_d = StDone;
         StDone:  if (handshake) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         StIdle:  in_ready = 1'b1;
         StRun:   busy = 1'b1;
         StDone: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready = 1'b0;
      endcase
   end

   // Datapath next-state
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      r_d      = r_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               acc_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, a};
               mplier_d = b;
               cnt_d    = '0;
            end
         end
         StRun: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shr;
            cnt_d    = cnt_q + CntW'(1);
            // r only changes on entry to DONE so it never shows partial sums.
            if (last_iter) r_d = acc_sum;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         r_q      <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         r_q      <= r_d;
      end
   end

   assign r = r_q;

endmodule
